sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word slave-to-asynchronous-SRAM sequencer with fully registered
// SRAM strobes, a configurable access phase and a read-to-write bus turnaround.
module sram_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_chipselect,
  input  logic                  s_read,
  input  logic                  s_write,
  input  logic [ADDR_W-1:0]     s_address,
  input  logic [DATA_W/8-1:0]   s_byteenable,
  input  logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W-1:0]     s_readdata,
  output logic                  s_readdatavalid,
  output logic                  s_waitrequest,
  inout  wire  [DATA_W-1:0]     SRAM_DQ,
  output logic [ADDR_W-1:0]     SRAM_ADDR,
  output logic [DATA_W/8-1:0]   SRAM_BE_n,
  output logic                  SRAM_WE_n,
  output logic                  SRAM_CE_n,
  output logic                  SRAM_OE_n
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    HOLD,
    TURN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic              after_read;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [BE_W-1:0]   be_sel;
  logic              dq_oe;
  logic              accept;
  logic              phase_last;
  logic              ce_n_d;
  logic              oe_n_d;
  logic              we_n_d;
  logic              dq_oe_d;
  logic [BE_W-1:0]   be_n_d;

  assign SRAM_DQ       = dq_oe ? wdata_q : 'z;
  assign s_waitrequest = (state != IDLE);

  // Strobes are registered, so they are derived here from the state being entered.
  always_comb begin
    accept     = (state == IDLE) && s_chipselect && (s_read || s_write);
    phase_last = (cnt == LAST_CNT);
    be_sel     = (state == IDLE) ? s_byteenable : be_q;
    state_next = state;

    case (state)
      IDLE: begin
        if (accept) begin
          if (s_read) begin
            state_next = READ;
          end else if (after_read) begin
            state_next = TURN;
          end else begin
            state_next = WRITE;
          end
        end
      end
      READ: begin
        if (phase_last) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (phase_last) begin
          state_next = HOLD;
        end
      end
      HOLD:    state_next = IDLE;
      TURN:    state_next = WRITE;
      default: state_next = IDLE;
    endcase

    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    be_n_d  = '1;

    case (state_next)
      READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
      end
      WRITE: begin
        dq_oe_d = 1'b1;
        be_n_d  = ~be_sel;
        if (|be_sel) begin
          ce_n_d = 1'b0;
          we_n_d = 1'b0;
        end
      end
      HOLD: begin
        dq_oe_d = 1'b1;
        be_n_d  = ~be_sel;
        ce_n_d  = ~(|be_sel);
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      after_read      <= 1'b0;
      wdata_q         <= '0;
      be_q            <= '0;
      dq_oe           <= 1'b0;
      SRAM_ADDR       <= '0;
      SRAM_BE_n       <= '1;
      SRAM_WE_n       <= 1'b1;
      SRAM_CE_n       <= 1'b1;
      SRAM_OE_n       <= 1'b1;
      s_readdata      <= '0;
      s_readdatavalid <= 1'b0;
    end else begin
      state     <= state_next;
      dq_oe     <= dq_oe_d;
      SRAM_BE_n <= be_n_d;
      SRAM_WE_n <= we_n_d;
      SRAM_CE_n <= ce_n_d;
      SRAM_OE_n <= oe_n_d;

      if (accept) begin
        SRAM_ADDR <= s_address;
        wdata_q   <= s_writedata;
        be_q      <= s_byteenable;
      end

      // Counter restarts on every phase entry and only advances while a phase continues.
      if ((state_next == state) && ((state == READ) || (state == WRITE))) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end

      after_read      <= (state == READ) && phase_last;
      s_readdatavalid <= (state == READ) && phase_last;
      if ((state == READ) && phase_last) begin
        s_readdata <= SRAM_DQ;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: drives sram_ctrl against a behavioural SRAM device, checks cycle timing
// by hand sequences, a vector table, and random traffic against a word-level memory model.
module tb_sram_ctrl;

  localparam int DW = 16;
  localparam int AW = 18;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_chipselect;
  logic          s_read;
  logic          s_write;
  logic [AW-1:0] s_address;
  logic [BW-1:0] s_byteenable;
  logic [DW-1:0] s_writedata;
  logic [DW-1:0] s_readdata;
  logic          s_readdatavalid;
  logic          s_waitrequest;
  wire  [DW-1:0] SRAM_DQ;
  logic [AW-1:0] SRAM_ADDR;
  logic [BW-1:0] SRAM_BE_n;
  logic          SRAM_WE_n;
  logic          SRAM_CE_n;
  logic          SRAM_OE_n;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic          sram_drv;

  sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_chipselect    (s_chipselect),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_address       (s_address),
    .s_byteenable    (s_byteenable),
    .s_writedata     (s_writedata),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .s_waitrequest   (s_waitrequest),
    .SRAM_DQ         (SRAM_DQ),
    .SRAM_ADDR       (SRAM_ADDR),
    .SRAM_BE_n       (SRAM_BE_n),
    .SRAM_WE_n       (SRAM_WE_n),
    .SRAM_CE_n       (SRAM_CE_n),
    .SRAM_OE_n       (SRAM_OE_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM device: drives on output-enable, stores lanes while write-enabled.
  assign sram_drv = !SRAM_CE_n && !SRAM_OE_n && SRAM_WE_n;
  assign SRAM_DQ  = sram_drv ? sram_mem[SRAM_ADDR] : 'z;

  always @(posedge clk) begin
    if (!SRAM_CE_n && !SRAM_WE_n) begin
      for (int b = 0; b < BW; b++) begin
        if (!SRAM_BE_n[b]) sram_mem[SRAM_ADDR][b*8 +: 8] <= SRAM_DQ[b*8 +: 8];
      end
    end
  end

  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic refWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    logic [DW-1:0] word;
    word = refRead(a);
    for (int b = 0; b < BW; b++) begin
      if (be[b]) word[b*8 +: 8] = d[b*8 +: 8];
    end
    ref_mem[a] = word;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    s_chipselect = 1'b0;
    s_read       = 1'b0;
    s_write      = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (s_waitrequest && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (s_waitrequest) checkOutput("idle_timeout", 32'(s_waitrequest), 32'd0);
  endtask

  task automatic driveCmd(input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
    s_chipselect = 1'b1;
    s_read       = r;
    s_write      = w;
    s_address    = a;
    s_writedata  = d;
    s_byteenable = be;
  endtask

  task automatic applyStimulus(input bit r, input bit w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [BW-1:0] be,
                               output logic [DW-1:0] rdata);
    int guard = 0;
    rdata = '0;
    waitIdle();
    driveCmd(r, w, a, d, be);
    @(negedge clk);
    idleInputs();
    if (r) begin
      while (!s_readdatavalid && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!s_readdatavalid) checkOutput("rdvalid_timeout", 32'(s_readdatavalid), 32'd1);
      rdata = s_readdata;
    end
  endtask

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t          tbl [12];
  logic [DW-1:0] rdata;
  logic [AW-1:0] pool [8];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
    reset        = 1'b1;
    s_address    = '0;
    s_writedata  = '0;
    s_byteenable = '0;
    idleInputs();

    repeat (2) @(negedge clk);
    checkOutput("rst_ce_n", 32'(SRAM_CE_n), 32'd1);
    checkOutput("rst_oe_n", 32'(SRAM_OE_n), 32'd1);
    checkOutput("rst_we_n", 32'(SRAM_WE_n), 32'd1);
    checkOutput("rst_be_n", 32'(SRAM_BE_n), 32'h3);
    checkOutput("rst_rdvalid", 32'(s_readdatavalid), 32'd0);
    checkOutput("rst_waitreq", 32'(s_waitrequest), 32'd0);
    checkOutput("rst_rdata", 32'(s_readdata), 32'd0);
    checkOutput("rst_addr", 32'(SRAM_ADDR), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Write timing, then a read accepted right after HOLD, then a write right after the read.
    waitIdle();
    driveCmd(1'b0, 1'b1, 18'h001A5, 16'hBEEF, 2'b11);
    refWrite(18'h001A5, 16'hBEEF, 2'b11);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      idleInputs();
      checkOutput($sformatf("wr_we_n_T%0d", k), 32'(SRAM_WE_n), (k <= 2) ? 32'd0 : 32'd1);
      checkOutput($sformatf("wr_wait_T%0d", k), 32'(s_waitrequest), (k <= 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wr_addr_T%0d", k), 32'(SRAM_ADDR), 32'h001A5);
      if (k <= 3) checkOutput($sformatf("wr_dq_T%0d", k), 32'(SRAM_DQ), 32'hBEEF);
    end

    driveCmd(1'b1, 1'b0, 18'h001A5, 16'h0000, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k != 3) idleInputs();
      checkOutput($sformatf("rw_oe_n_T%0d", k), 32'(SRAM_OE_n), (k <= 2) ? 32'd0 : 32'd1);
      checkOutput($sformatf("rw_rdvalid_T%0d", k), 32'(s_readdatavalid), (k == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rw_we_n_T%0d", k), 32'(SRAM_WE_n), (k == 5 || k == 6) ? 32'd0 : 32'd1);
      checkOutput($sformatf("rw_wait_T%0d", k), 32'(s_waitrequest), (k == 3 || k == 8) ? 32'd0 : 32'd1);
      if (k == 3) begin
        checkOutput("rw_rdata", 32'(s_readdata), 32'hBEEF);
        driveCmd(1'b0, 1'b1, 18'h00077, 16'h0F0F, 2'b11);
        refWrite(18'h00077, 16'h0F0F, 2'b11);
      end
      if (k == 4) checkOutput("turn_ce_n", 32'(SRAM_CE_n), 32'd1);
      if (k >= 5 && k <= 7) checkOutput($sformatf("rw_dq_T%0d", k), 32'(SRAM_DQ), 32'h0F0F);
    end

    // Reset during a read phase, then during a write phase.
    waitIdle();
    driveCmd(1'b1, 1'b0, 18'h00077, 16'h0000, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      idleInputs();
      reset = (k == 1);
      checkOutput($sformatf("abrd_rdvalid_T%0d", k), 32'(s_readdatavalid), 32'd0);
      checkOutput($sformatf("abrd_oe_n_T%0d", k), 32'(SRAM_OE_n), (k == 1) ? 32'd0 : 32'd1);
      if (k >= 2) checkOutput($sformatf("abrd_ce_n_T%0d", k), 32'(SRAM_CE_n), 32'd1);
      if (k >= 2) checkOutput($sformatf("abrd_wait_T%0d", k), 32'(s_waitrequest), 32'd0);
    end
    waitIdle();
    driveCmd(1'b0, 1'b1, 18'h00077, 16'hDEAD, 2'b11);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      idleInputs();
      reset = (k == 1);
      checkOutput($sformatf("abwr_we_n_T%0d", k), 32'(SRAM_WE_n), (k == 1) ? 32'd0 : 32'd1);
    end

    tbl[0]  = '{1'b0, 1'b1, 18'h001A5, 16'hBEEF, 2'b11, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 18'h001A5, 16'h0000, 2'b00, 16'hBEEF};
    tbl[2]  = '{1'b0, 1'b1, 18'h001A5, 16'h12FF, 2'b10, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 18'h001A5, 16'h0000, 2'b01, 16'h12EF};
    tbl[4]  = '{1'b0, 1'b1, 18'h3FFFF, 16'hA5A5, 2'b01, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 2'b00, 16'h00A5};
    tbl[6]  = '{1'b0, 1'b1, 18'h00000, 16'hFFFF, 2'b00, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 18'h00000, 16'h0000, 2'b11, 16'h0000};
    tbl[8]  = '{1'b1, 1'b1, 18'h001A5, 16'h5555, 2'b11, 16'h12EF};
    tbl[9]  = '{1'b1, 1'b0, 18'h001A5, 16'h0000, 2'b00, 16'h12EF};
    tbl[10] = '{1'b0, 1'b1, 18'h00000, 16'h1234, 2'b11, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 18'h00000, 16'h0000, 2'b00, 16'h1234};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].be, rdata);
      if (tbl[i].rd) begin
        checkOutput($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].exp_rdata));
        checkOutput($sformatf("tbl%0d_addr", i), 32'(SRAM_ADDR), 32'(tbl[i].addr));
      end else begin
        refWrite(tbl[i].addr, tbl[i].data, tbl[i].be);
      end
    end

    pool = '{18'h00000, 18'h00001, 18'h00002, 18'h001A5, 18'h3FFFF, 18'h15555, 18'h2AAAA, 18'h00010};
    for (int i = 0; i < 300; i++) begin
      int            kind;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [BW-1:0] be;
      kind = int'($urandom_range(0, 9));
      a    = pool[$urandom_range(0, 7)];
      d    = DW'($urandom);
      be   = BW'($urandom);
      if (kind <= 4) begin
        applyStimulus(1'b0, 1'b1, a, d, be, rdata);
        refWrite(a, d, be);
      end else begin
        applyStimulus(1'b1, kind == 9, a, d, be, rdata);
        checkOutput($sformatf("rnd%0d_rdata@%0h", i, a), 32'(rdata), 32'(refRead(a)));
      end
    end

    waitIdle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
